kanagawa_width_down_converter: RTL and testbench



---
 rtl/kanagawa_width_down_converter.sv | 88 ++++++++
 tb/tb_kanagawa_width_down_converter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_width_down_converter.sv
// Width down-converter: takes one WIDTH-bit word per handshake and emits it as
// RATIO narrower beats, least-significant slice first, with a last-beat flag.
module kanagawa_width_down_converter #(
  parameter int WIDTH = 64,
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         input_data_in,
  input  logic                     input_valid_in,
  output logic                     input_ready_out,
  output logic [WIDTH/RATIO-1:0]   output_data_out,
  output logic                     output_valid_out,
  output logic                     output_last_out,
  input  logic                     output_ready_in
);

  localparam int OUT_WIDTH = WIDTH / RATIO;
  localparam int CNT_WIDTH = $clog2(RATIO);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(RATIO - 1);

  if (RATIO < 2) begin : g_bad_ratio
    $error("kanagawa_width_down_converter: RATIO must be >= 2");
  end
  if (WIDTH % RATIO != 0) begin : g_bad_width
    $error("kanagawa_width_down_converter: WIDTH must be a multiple of RATIO");
  end

  logic                 hold_valid_ff;
  logic [WIDTH-1:0]     hold_data_ff;
  logic [CNT_WIDTH-1:0] beat_cnt_ff;

  logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
  logic is_last;
  logic beat_accept;
  logic load;

  assign slices      = hold_data_ff;
  assign is_last     = (beat_cnt_ff == LAST_BEAT);
  assign beat_accept = hold_valid_ff && output_ready_in;

  assign output_valid_out = hold_valid_ff;
  assign output_data_out  = slices[beat_cnt_ff];
  assign output_last_out  = hold_valid_ff && is_last;
  // Combinational from output_ready_in so a new word lands in the last-beat cycle.
  assign input_ready_out  = !hold_valid_ff || (output_ready_in && is_last);
  assign load             = input_valid_in && input_ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_ff <= 1'b0;
      beat_cnt_ff   <= '0;
    end else if (load) begin
      hold_valid_ff <= 1'b1;
      beat_cnt_ff   <= '0;
    end else if (beat_accept) begin
      if (is_last) begin
        hold_valid_ff <= 1'b0;
        beat_cnt_ff   <= '0;
      end else begin
        beat_cnt_ff <= beat_cnt_ff + 1'b1;
      end
    end
  end

  // Data register carries no reset; it is only observed while hold_valid_ff is set.
  always_ff @(posedge clk) begin
    if (load) begin
      hold_data_ff <= input_data_in;
    end
  end

`ifndef SYNTHESIS
`ifndef NO_DYNAMIC_ASSERTS
  a_backpressure_stable: assert property (@(posedge clk) disable iff (rst)
    (output_valid_out && !output_ready_in) |=>
      (output_valid_out && $stable(output_data_out) && $stable(output_last_out)));

  a_last_implies_valid: assert property (@(posedge clk) disable iff (rst)
    output_last_out |-> output_valid_out);

  a_upstream_hold: assert property (@(posedge clk) disable iff (rst)
    (input_valid_in && !input_ready_out) |=>
      (input_valid_in && $stable(input_data_in)));
`endif
`endif

endmodule

// File: tb/tb_kanagawa_width_down_converter.sv
// Directed and randomized bench for the width down-converter (WIDTH=32, RATIO=4).
module tb_kanagawa_width_down_converter;

  localparam int WIDTH = 32;
  localparam int RATIO = 4;
  localparam int OUT_WIDTH = WIDTH / RATIO;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     input_data_in;
  logic                 input_valid_in;
  logic                 input_ready_out;
  logic [OUT_WIDTH-1:0] output_data_out;
  logic                 output_valid_out;
  logic                 output_last_out;
  logic                 output_ready_in;

  int checks = 0;
  int errors = 0;

  kanagawa_width_down_converter #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk              (clk),
    .rst              (rst),
    .input_data_in    (input_data_in),
    .input_valid_in   (input_valid_in),
    .input_ready_out  (input_ready_out),
    .output_data_out  (output_data_out),
    .output_valid_out (output_valid_out),
    .output_last_out  (output_last_out),
    .output_ready_in  (output_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one presented beat; caller has already settled inputs.
  task automatic check_beat(input string tag, input logic [7:0] exp_data, input logic exp_last);
    check({tag, "_valid"}, 32'(output_valid_out), 32'd1);
    check({tag, "_data"}, 32'(output_data_out), 32'(exp_data));
    check({tag, "_last"}, 32'(output_last_out), 32'(exp_last));
  endtask

  logic [31:0] stream_words [3];
  logic [7:0]  exp_byte;
  logic [31:0] word_tmp;
  logic [7:0]  exp_q [$];
  int          beats_seen;
  int          words_sent;
  int          cycles;
  logic        hs_in;

  initial begin
    stream_words[0] = 32'h1312_1110;
    stream_words[1] = 32'h2322_2120;
    stream_words[2] = 32'h3332_3130;

    // Reset with a valid word waiting upstream.
    rst = 1'b1;
    input_valid_in = 1'b1;
    input_data_in = 32'h1234_5678;
    output_ready_in = 1'b1;
    tick();
    check("rst_valid_c1", 32'(output_valid_out), 32'd0);
    tick();
    check("rst_valid_c2", 32'(output_valid_out), 32'd0);
    rst = 1'b0;
    input_valid_in = 1'b0;
    #1;
    check("rst_ready", 32'(input_ready_out), 32'd1);
    check("rst_last", 32'(output_last_out), 32'd0);
    tick();
    check("rst_no_beat", 32'(output_valid_out), 32'd0);

    // Single word.
    input_data_in = 32'hDDCC_BBAA;
    input_valid_in = 1'b1;
    #1;
    check("single_ready", 32'(input_ready_out), 32'd1);
    tick();
    input_valid_in = 1'b0;
    #1; check_beat("single_b0", 8'hAA, 1'b0); tick();
    #1; check_beat("single_b1", 8'hBB, 1'b0); tick();
    #1; check_beat("single_b2", 8'hCC, 1'b0); tick();
    #1; check_beat("single_b3", 8'hDD, 1'b1); tick();
    #1;
    check("single_done", 32'(output_valid_out), 32'd0);

    // Three back-to-back words, no bubble expected.
    input_data_in = stream_words[0];
    input_valid_in = 1'b1;
    #1;
    tick();
    input_data_in = stream_words[1];
    for (int k = 0; k < 12; k++) begin
      #1;
      word_tmp = stream_words[k / 4];
      exp_byte = word_tmp[8*(k%4) +: 8];
      check_beat($sformatf("stream_k%0d", k), exp_byte, (k % 4) == 3);
      check($sformatf("stream_rdy_k%0d", k), 32'(input_ready_out), 32'((k % 4) == 3));
      tick();
      if ((k % 4) == 3) begin
        if (k / 4 + 2 < 3) input_data_in = stream_words[k / 4 + 2];
        else input_valid_in = 1'b0;
      end
    end
    #1;
    check("stream_done", 32'(output_valid_out), 32'd0);

    // Backpressure while beat 1 is shown.
    input_data_in = 32'h8765_4321;
    input_valid_in = 1'b1;
    #1;
    tick();
    input_valid_in = 1'b0;
    #1; check_beat("bp_b0", 8'h21, 1'b0); tick();
    output_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_beat($sformatf("bp_hold%0d", c), 8'h43, 1'b0);
      check($sformatf("bp_rdy%0d", c), 32'(input_ready_out), 32'd0);
      tick();
    end
    output_ready_in = 1'b1;
    #1; check_beat("bp_b1", 8'h43, 1'b0); tick();
    #1; check_beat("bp_b2", 8'h65, 1'b0); tick();
    #1; check_beat("bp_b3", 8'h87, 1'b1); tick();
    #1;
    check("bp_done", 32'(output_valid_out), 32'd0);

    // Reset after beat 1 has been accepted.
    input_data_in = 32'hAABB_CCDD;
    input_valid_in = 1'b1;
    #1;
    tick();
    input_valid_in = 1'b0;
    #1; check_beat("mrst_b0", 8'hDD, 1'b0); tick();
    #1; check_beat("mrst_b1", 8'hCC, 1'b0); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(output_valid_out), 32'd0);
    check("mrst_ready", 32'(input_ready_out), 32'd1);
    input_data_in = 32'h4433_2211;
    input_valid_in = 1'b1;
    #1;
    tick();
    input_valid_in = 1'b0;
    #1; check_beat("mrst_n0", 8'h11, 1'b0); tick();
    #1; check_beat("mrst_n1", 8'h22, 1'b0); tick();
    #1; check_beat("mrst_n2", 8'h33, 1'b0); tick();
    #1; check_beat("mrst_n3", 8'h44, 1'b1); tick();
    #1;
    check("mrst_done", 32'(output_valid_out), 32'd0);

    // Random valid/ready with a byte scoreboard.
    beats_seen = 0;
    words_sent = 0;
    cycles = 0;
    while ((words_sent < 1000 || exp_q.size() != 0 || output_valid_out) && cycles < 20000) begin
      output_ready_in = ($urandom_range(0, 9) < 7);
      if (!input_valid_in && words_sent < 1000 && $urandom_range(0, 3) != 0) begin
        input_valid_in = 1'b1;
        input_data_in = $urandom;
      end
      #1;
      if (output_valid_out && output_ready_in) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_byte = exp_q.pop_front();
          check("rand_data", 32'(output_data_out), 32'(exp_byte));
          check("rand_last", 32'(output_last_out), 32'((beats_seen % 4) == 3));
        end
        beats_seen++;
      end
      hs_in = input_valid_in && input_ready_out;
      if (hs_in) begin
        for (int b = 0; b < 4; b++) exp_q.push_back(input_data_in[8*b +: 8]);
        words_sent++;
      end
      tick();
      cycles++;
      if (hs_in) input_valid_in = 1'b0;
    end
    check("rand_timeout", 32'(cycles < 20000), 32'd1);
    check("rand_beats", 32'(beats_seen), 32'd4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
